// File: rtl/i2s_audio_receiver.sv
// I2S receiver: oversamples bclk/lrclk/adcdat in the clk domain and queues {left,right} pairs in a FWFT FIFO.
// Latency: a pair is visible on out_valid 3 clk after the bclk edge carrying the last right bit.
// Backpressure: out_valid/out_ready; a pair completing into a full FIFO without a pop is dropped and flags overflow.
module i2s_audio_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          bclk,
  input  logic                          lrclk,
  input  logic                          adcdat,
  output logic [DATA_WIDTH-1:0]         out_left,
  output logic [DATA_WIDTH-1:0]         out_right,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {WAIT_FRAME, SHIFT, PAD} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  // Input synchronizers; bclk_hist gives the rising-edge history.
  logic bclk_s1, bclk_s2, bclk_hist;
  logic lrclk_s1, lrclk_s2;
  logic adcdat_s1, adcdat_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_hist <= 1'b0;
      lrclk_s1  <= 1'b0;
      lrclk_s2  <= 1'b0;
      adcdat_s1 <= 1'b0;
      adcdat_s2 <= 1'b0;
    end else begin
      bclk_s1   <= bclk;
      bclk_s2   <= bclk_s1;
      bclk_hist <= bclk_s2;
      lrclk_s1  <= lrclk;
      lrclk_s2  <= lrclk_s1;
      adcdat_s1 <= adcdat;
      adcdat_s2 <= adcdat_s1;
    end
  end

  logic bit_event;
  logic lr_prev;
  logic lr_change;

  assign bit_event = bclk_s2 & ~bclk_hist;
  assign lr_change = lrclk_s2 ^ lr_prev;

  // Deserializer state
  state_t                state, state_nxt;
  logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  channel, channel_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [DATA_WIDTH-1:0] left_hold, left_hold_nxt;
  logic                  left_ok, left_ok_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic                  push;
  pair_t                 push_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_FRAME;
      bit_cnt   <= '0;
      channel   <= 1'b0;
      shift_reg <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      channel   <= channel_nxt;
      shift_reg <= shift_nxt;
      left_hold <= left_hold_nxt;
      left_ok   <= left_ok_nxt;
      if (bit_event) begin
        lr_prev <= lrclk_s2;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    channel_nxt   = channel;
    shift_nxt     = shift_reg;
    left_hold_nxt = left_hold;
    left_ok_nxt   = left_ok;
    push          = 1'b0;
    // Word as it stands once the current bit is shifted in.
    word          = (shift_reg << 1) | {{(DATA_WIDTH-1){1'b0}}, adcdat_s2};
    push_dat.left  = left_hold;
    push_dat.right = word;

    if (bit_event) begin
      case (state)
        WAIT_FRAME: begin
          if (lr_change) begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
            channel_nxt = lrclk_s2;
            shift_nxt   = '0;
          end
        end
        SHIFT: begin
          if (lr_change) begin
            // Slot ended before the word filled: drop it, and a broken left voids pairing.
            bit_cnt_nxt = '0;
            channel_nxt = lrclk_s2;
            shift_nxt   = '0;
            if (!channel) begin
              left_ok_nxt = 1'b0;
            end
          end else begin
            shift_nxt   = word;
            bit_cnt_nxt = bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state_nxt = PAD;
              if (!channel) begin
                left_hold_nxt = word;
                left_ok_nxt   = 1'b1;
              end else if (left_ok) begin
                push        = 1'b1;
                left_ok_nxt = 1'b0;
              end
            end
          end
        end
        PAD: begin
          if (lr_change) begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
            channel_nxt = lrclk_s2;
            shift_nxt   = '0;
          end
        end
        default: begin
          state_nxt = WAIT_FRAME;
        end
      endcase
    end
  end

  // First-word-fall-through pair FIFO
  pair_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, push_acc, drop;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (fifo_count == FULL_CNT);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_acc  = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_left  = mem[rd_ptr].left;
  assign out_right = mem[rd_ptr].right;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_acc, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/i2s_audio_receiver.md
I2S_AUDIO_RECEIVER -- requirements
Module: i2s_audio_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, giving the audio sample width in bits (legal range 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of stereo pairs buffered (power of 2, ≥2).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bclk, input, 1 bit: I2S bit clock, asynchronous to clk, frequency ≤ clk/4.
REQ-006 SHALL have port lrclk, input, 1 bit: I2S word select, where 0 means left and 1 means right.
REQ-007 SHALL have port adcdat, input, 1 bit: I2S serial data, MSB first.
REQ-008 SHALL have port out_left, output, DATA_WIDTH bits: the left sample at the FIFO head.
REQ-009 SHALL have port out_right, output, DATA_WIDTH bits: the right sample at the FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: high when the FIFO is not empty.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accept.
REQ-012 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: the number of stored pairs.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag set when a pair is dropped.
REQ-014 SHALL have port clear_overflow, input, 1 bit: a synchronous clear of overflow.

Function
REQ-015 SHALL pass bclk, lrclk and adcdat through 2-flop synchronizers plus one history flop for bclk.
REQ-016 SHALL detect a bit event when synchronized bclk is 1 and its history value is 0; all capture occurs only on bit events.
REQ-017 SHALL, on each bit event, compare synchronized lrclk with lr_prev (the lrclk sampled at the previous bit event), then update lr_prev.
REQ-018 SHALL implement the states WAIT_FRAME, SHIFT and PAD, with a bit counter bit_cnt of width clog2(DATA_WIDTH+1).
REQ-019 WAIT_FRAME: ignore data; on the first bit event with an lrclk change, go to SHIFT with bit_cnt=0 and channel=new lrclk. No bit is captured on that event (I2S one-bit delay).
REQ-020 SHIFT: on each bit event without an lrclk change, shift adcdat into the LSB of shift_reg and increment bit_cnt.
REQ-021 SHIFT: when bit_cnt reaches DATA_WIDTH, the word is complete; go to PAD.
REQ-022 PAD: ignore bits beyond DATA_WIDTH until the next lrclk change.
REQ-023 SHALL, on any lrclk change seen in SHIFT or PAD, restart with bit_cnt=0 and channel=new lrclk, staying in or returning to SHIFT.
REQ-024 SHALL, on completion of a left word, store it in left_hold and set left_ok.
REQ-025 SHALL, on completion of a right word with left_ok=1, push {left_hold, right} to the FIFO in the same clk cycle and clear left_ok.
REQ-026 SHALL ignore a completed right word when left_ok=0 (unpaired right).
REQ-027 SHALL discard a short word (lrclk change while in SHIFT with bit_cnt<DATA_WIDTH), with no push; a short left word clears left_ok.
REQ-028 SHALL make the FIFO first-word-fall-through: out_left/out_right show the head entry whenever out_valid=1, and pop occurs when out_valid & out_ready.
REQ-029 SHALL accept a push when count<FIFO_DEPTH, or when count=FIFO_DEPTH and a pop occurs in the same cycle.
REQ-030 SHALL, for a push into a full FIFO with no pop, drop the pair, set overflow, and leave the FIFO contents unchanged.
REQ-031 SHALL, when push and pop occur together, leave fifo_count unchanged and wrap the pointers modulo FIFO_DEPTH.
REQ-032 SHALL hold overflow until clear_overflow=1; if set and clear occur in the same cycle, set wins.
REQ-033 SHALL hold out_left/out_right stable while out_valid=1 and out_ready=0.
REQ-034 SHALL make latency from the bclk rising edge carrying the last right bit to out_valid rising ≤ 5 clk cycles (3 sync + 1 capture + 1 FIFO).

Reset
REQ-035 SHALL, on reset_n low, asynchronously set state=WAIT_FRAME, bit_cnt=0, shift_reg=0, left_hold=0, left_ok=0, lr_prev=0, synchronizer flops=0, pointers=0, fifo_count=0, out_valid=0, out_left=0, out_right=0, overflow=0.
REQ-036 SHALL, when reset is asserted mid-frame, discard any partial word; after release, no pair is pushed before a full left word followed by a full right word.

Verification
REQ-037 SHALL be verified as follows: with DATA_WIDTH=24, bclk=clk/8, 32-bit slots, L=0xA5A5A5 and R=0x5A5A5A with out_ready=1 → exactly one pair out_left=0xA5A5A5, out_right=0x5A5A5A, with out_valid high within 5 clk of the last R bit.
REQ-038 SHALL be verified as follows: with out_ready=0 and 5 frames (L=n, R=0x100+n, n=1..5) → fifo_count=4, overflow=1, and draining yields pairs n=1..4 in order.
REQ-039 SHALL be verified as follows: starting mid-right-slot after reset, then a full frame L=0x123456, R=0x654321 → the first pushed pair is exactly (0x123456, 0x654321).
REQ-040 SHALL be verified as follows: with a left slot of only 16 bclk, then a full right word → no push and fifo_count stays 0.
REQ-041 SHALL be verified as follows: with the FIFO full and out_ready=1 in the exact cycle a new pair completes → push accepted, fifo_count stays 4, overflow stays 0.
REQ-042 SHALL be verified as follows: with overflow=1, a clear_overflow pulse coinciding with a new drop → overflow remains 1; a clear in a later idle cycle → overflow becomes 0.
